// File: rtl/sprite_pkg.sv
// Shared sprite definitions: frame-writer state encoding, default sprite geometry
// and the RAM address width derivation used by writers and renderers alike.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } sprite_state_t;

  localparam int SPRITE_WIDTH  = 200;
  localparam int SPRITE_HEIGHT = 200;

  function automatic int sprite_addr_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

  localparam int SPRITE_ADDR_W = sprite_addr_w(SPRITE_WIDTH, SPRITE_HEIGHT);

endpackage

// File: rtl/sprite_xy_counter.sv
// Row-major x/y pixel counter with a running linear address (no multiplier).
// Zero latency on last flag; advances only on step, clr wins over step.
module sprite_xy_counter
  import sprite_pkg::*;
#(
  parameter int WIDTH  = SPRITE_WIDTH,
  parameter int HEIGHT = SPRITE_HEIGHT,
  parameter int ADDR_W = sprite_addr_w(WIDTH, HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  assign last = (x == X_MAX) && (y == Y_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clr) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (step) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
      // The linear address tracks x + y*WIDTH by simple increment.
      addr <= last ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_frame_writer.sv
// Write side of the sprite RAM: optional FILL_INDEX clear pass, then row-major stream load.
// Write port registered (1-cycle latency); ready only in LOAD, stalls hold the counters.
module sprite_frame_writer
  import sprite_pkg::*;
#(
  parameter int                WIDTH      = SPRITE_WIDTH,
  parameter int                HEIGHT     = SPRITE_HEIGHT,
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = sprite_addr_w(WIDTH, HEIGHT),
  parameter logic [DATA_W-1:0] FILL_INDEX = '0
) (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              clear_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] wdata_out,
  output logic              we_out,
  output logic              busy_out,
  output logic              done_out
);

  sprite_state_t     state;
  sprite_state_t     state_nxt;
  logic              start_ok;
  logic              accept;
  logic              cnt_clr;
  logic              cnt_step;
  logic              cnt_last;
  logic [ADDR_W-1:0] cnt_addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  assign start_ok = start_in && ((state == IDLE) || (state == DONE));
  assign accept   = valid_in && (state == LOAD);

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in) state_nxt = clear_in ? CLEAR : LOAD;
      DONE:    state_nxt = start_in ? (clear_in ? CLEAR : LOAD) : IDLE;
      CLEAR:   if (cnt_last) state_nxt = LOAD;
      LOAD:    if (accept && cnt_last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_out = (state == LOAD);
    busy_out  = (state == CLEAR) || (state == LOAD);
    // Counters restart on entry to either pass.
    cnt_clr   = start_ok || ((state == CLEAR) && cnt_last);
    cnt_step  = (state == CLEAR) || accept;
    wr_en     = cnt_step;
    wr_data   = (state == CLEAR) ? FILL_INDEX : data_in;
  end

  sprite_xy_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_xy (
    .clk   (pixel_clk_in),
    .rst_n (rst_n_in),
    .clr   (cnt_clr),
    .step  (cnt_step),
    .addr  (cnt_addr),
    .last  (cnt_last)
  );

  // done_out lines up with the final load write; address/data hold between writes.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      we_out    <= 1'b0;
      done_out  <= 1'b0;
      addr_out  <= '0;
      wdata_out <= '0;
    end else begin
      we_out   <= wr_en;
      done_out <= accept && cnt_last;
      if (wr_en) begin
        addr_out  <= cnt_addr;
        wdata_out <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_frame_writer.sv
// Bench for sprite_frame_writer on a 4x3 frame: stream-level scoreboard plus literal frame checks.
module tb_sprite_frame_writer;

  localparam int NPIX = 12;

  logic       pixel_clk_in = 1'b0;
  logic       rst_n_in     = 1'b0;
  logic       start_in     = 1'b0;
  logic       clear_in     = 1'b0;
  logic [7:0] data_in      = 8'h00;
  logic       valid_in     = 1'b0;
  logic       ready_out;
  logic [3:0] addr_out;
  logic [7:0] wdata_out;
  logic       we_out;
  logic       busy_out;
  logic       done_out;

  sprite_frame_writer #(
    .WIDTH      (4),
    .HEIGHT     (3),
    .DATA_W     (8),
    .ADDR_W     (4),
    .FILL_INDEX (8'hAA)
  ) dut (
    .pixel_clk_in (pixel_clk_in),
    .rst_n_in     (rst_n_in),
    .start_in     (start_in),
    .clear_in     (clear_in),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .addr_out     (addr_out),
    .wdata_out    (wdata_out),
    .we_out       (we_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       last;
  } wr_t;

  // Model: a frame is a pending clear of NPIX cycles followed by NPIX accepted beats.
  wr_t        q[$];
  bit         act = 0;
  int         clr_left = 0;
  int         beats = 0;
  bit         acc_prev = 0;
  int         log_n = 0;
  int         done_n = 0;
  logic [3:0] log_addr[64];
  logic [7:0] log_data[64];

  always @(negedge pixel_clk_in) begin
    if (!rst_n_in) begin
      q.delete();
      act = 0; clr_left = 0; beats = 0; acc_prev = 0;
    end else begin
      wr_t e;
      chk("busy", busy_out, act);
      chk("ready", ready_out, act && (clr_left == 0));
      if (acc_prev) chk("load_latency", we_out, 1);
      if (done_out) done_n++;
      if (we_out) begin
        if (log_n < 64) begin
          log_addr[log_n] = addr_out;
          log_data[log_n] = wdata_out;
        end
        log_n++;
        if (q.size() == 0) chk("unexpected_write", we_out, 0);
        else begin
          e = q.pop_front();
          chk("wr_addr", addr_out, e.addr);
          chk("wr_data", wdata_out, e.data);
          chk("done_on_write", done_out, e.last);
        end
      end else begin
        chk("done_no_write", done_out, 0);
      end
      acc_prev = 0;
      if (act) begin
        if (clr_left > 0) clr_left--;
        else if (valid_in) begin
          q.push_back('{addr: 4'(beats), data: data_in, last: (beats == NPIX - 1)});
          beats++;
          acc_prev = 1;
          if (beats == NPIX) act = 0;
        end
      end else if (start_in) begin
        act = 1; beats = 0; log_n = 0; done_n = 0;
        clr_left = clear_in ? NPIX : 0;
        if (clear_in)
          for (int i = 0; i < NPIX; i++) q.push_back('{addr: 4'(i), data: 8'hAA, last: 1'b0});
      end
    end
  end

  task automatic start_frame(input logic clr);
    @(posedge pixel_clk_in); #1;
    start_in = 1'b1; clear_in = clr;
    @(posedge pixel_clk_in); #1;
    start_in = 1'b0; clear_in = 1'b0;
  endtask

  // Offers beats base+k until n are accepted; optional stray start pulse and tail behaviour.
  task automatic send_beats(input int n, input logic [7:0] base, input bit rnd,
                            input int start_at, input bit tail_valid, input bit tail_start);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 400) begin
      @(posedge pixel_clk_in); #1;
      valid_in = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      data_in  = base + sent[7:0];
      start_in = (sent == start_at) && valid_in;
      clear_in = start_in;
      #3;
      if (valid_in && ready_out) sent++;
      guard++;
    end
    if (guard >= 400) chk("beat_timeout", sent, n);
    @(posedge pixel_clk_in); #1;
    start_in = tail_start; clear_in = 1'b0;
    valid_in = tail_valid; data_in = 8'h99;
    if (tail_valid) repeat (5) @(posedge pixel_clk_in);
    if (tail_start) begin @(posedge pixel_clk_in); #1; end
    start_in = 1'b0; valid_in = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge pixel_clk_in);
    #1;
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #1;
    chk("rst_we", we_out, 0);
    chk("rst_ready", ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_addr", addr_out, 0);
    repeat (2) @(posedge pixel_clk_in);
    #2 rst_n_in = 1'b1;

    // Idle with valid asserted: nothing may be written.
    @(posedge pixel_clk_in); #1 valid_in = 1'b1; data_in = 8'h55;
    repeat (4) @(posedge pixel_clk_in);
    #1 valid_in = 1'b0;

    // Plain load.
    start_frame(1'b0);
    send_beats(NPIX, 8'h00, 0, -1, 0, 0);
    settle();
    chk("s2_writes", log_n, 12);
    chk("s2_done", done_n, 1);
    chk("s2_d0", log_data[0], 8'h00);
    chk("s2_d5", log_data[5], 8'h05);
    chk("s2_a11", log_addr[11], 4'd11);
    chk("s2_d11", log_data[11], 8'h0B);

    // Clear then load.
    start_frame(1'b1);
    send_beats(NPIX, 8'h20, 0, -1, 0, 0);
    settle();
    chk("s3_writes", log_n, 24);
    chk("s3_done", done_n, 1);
    chk("s3_fill0", log_data[0], 8'hAA);
    chk("s3_fill_a11", log_addr[11], 4'd11);
    chk("s3_load_a0", log_addr[12], 4'd0);
    chk("s3_load_d0", log_data[12], 8'h20);
    chk("s3_load_d11", log_data[23], 8'h2B);

    // Random gaps.
    start_frame(1'b0);
    send_beats(NPIX, 8'h40, 1, -1, 0, 0);
    settle();
    chk("s4_writes", log_n, 12);
    for (int i = 0; i < NPIX; i++) chk("s4_seq_addr", log_addr[i], i);
    chk("s4_wrap_a3", log_addr[3], 4'd3);
    chk("s4_wrap_a4", log_addr[4], 4'd4);
    chk("s4_wrap_d4", log_data[4], 8'h44);

    // start_in (with clear) mid-load must be ignored.
    start_frame(1'b0);
    send_beats(NPIX, 8'h50, 0, 5, 0, 0);
    settle();
    chk("s5_writes", log_n, 12);
    chk("s5_done", done_n, 1);
    chk("s5_d11", log_data[11], 8'h5B);

    // Extra beats after the last one are not accepted.
    start_frame(1'b0);
    send_beats(NPIX, 8'h60, 0, -1, 1, 0);
    settle();
    chk("s6_writes", log_n, 12);
    chk("s6_done", done_n, 1);

    // Restart from DONE goes straight back to address 0.
    start_frame(1'b0);
    send_beats(NPIX, 8'h60, 0, -1, 0, 1);
    send_beats(NPIX, 8'h70, 0, -1, 0, 0);
    settle();
    chk("s6b_writes", log_n, 12);
    chk("s6b_a0", log_addr[0], 4'd0);
    chk("s6b_d0", log_data[0], 8'h70);

    // Reset mid-load.
    start_frame(1'b0);
    send_beats(5, 8'h80, 0, -1, 0, 0);
    @(posedge pixel_clk_in); #1 valid_in = 1'b1;
    #2 rst_n_in = 1'b0;
    #1;
    chk("mid_rst_we", we_out, 0);
    chk("mid_rst_ready", ready_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_done", done_out, 0);
    chk("mid_rst_addr", addr_out, 0);
    chk("mid_rst_wdata", wdata_out, 0);
    @(posedge pixel_clk_in); #2 rst_n_in = 1'b1;
    repeat (5) @(posedge pixel_clk_in);
    #1 valid_in = 1'b0;
    start_frame(1'b0);
    send_beats(NPIX, 8'h90, 0, -1, 0, 0);
    settle();
    chk("post_rst_writes", log_n, 12);
    chk("post_rst_a0", log_addr[0], 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
